seed_hit_scanner: RTL and testbench
===================================

// Module: seed_hit_scanner
// PURPOSE
//  Upstream feeder of the ungapped-extension FSM. Compares one 22-bit (11-base, 2b/base) query seed
//  against every base-aligned window of a 512-bit DB line, then issues matches one at a time as
//  (shift, line index, query location) with a start pulse. Waits for the extender's stop before
//  issuing the next hit. The extender fetches DB data itself; this block only locates seeds.
// PARAMETERS
//  LINE_W    512  DB line width in bits
//  SEED_W    22   seed width in bits
//  STEP      2    window stride in bits (one base)
//  MAX_HITS  16   hits issued per line; excess hits dropped
// PORTS
//  clk           in   1    clock
//  rst           in   1    reset, synchronous, active-high
//  cfg_valid     in   1    load cfg_seed/cfg_loc; accepted only in IDLE
//  cfg_seed      in   22   query seed bits
//  cfg_loc       in   9    bit offset of seed in query line -> hit_qloc
//  line_valid    in   1    DB line offered
//  line_ready    out  1    line accepted when line_valid & line_ready
//  line_data     in   512  DB line
//  line_idx      in   17   DB line number -> hit_line
//  hit_start     out  1    one-cycle pulse: hit fields valid, extender to start
//  hit_shift     out  9    window bit offset (even, 0..490)
//  hit_line      out  17   line index of the hit
//  hit_qloc      out  9    query seed location
//  exp_stop      in   1    extender stop flag (rises when extension ends)
//  line_done     out  1    one-cycle pulse: all hits of current line handled
//  hit_total     out  16   saturating count of hits issued since reset
//  hit_overflow  out  1    sticky: a line had > MAX_HITS matches
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, seed_loaded=0, match vector cleared; exp_stop edge reg = 0.
//  Windows: N_POS = (LINE_W-SEED_W)/STEP+1 = 246; window j = line_data[2j+21:2j]. No cross-line hits.
//  States:
//   IDLE   : line_ready = seed_loaded. cfg_valid loads seed (cfg wins over line if both high; line not
//            accepted that cycle). On line handshake latch line_idx, cnt_line=0 -> MATCH.
//   MATCH  : register 246-bit compare vector (window j == seed) -> SCAN. 1 cycle.
//   SCAN   : vector empty or cnt_line==MAX_HITS -> pulse line_done, IDLE (set hit_overflow if bits
//            remain). Else j = lowest set bit; hit_shift<=2j, hit_line, hit_qloc registered -> ISSUE.
//   ISSUE  : if exp_stop==0: hit_start=1 this cycle, clear bit j, cnt_line++, hit_total++ (sat at
//            FFFF) -> WAIT. If exp_stop==1: hold in ISSUE, no pulse.
//   WAIT   : on exp_stop rising edge (exp_stop & ~stop_q) -> SCAN.
//  hit_shift/line/qloc stay stable from ISSUE pulse until the next ISSUE pulse.
//  Latency: line handshake -> first hit_start = 3 cycles (MATCH, SCAN, ISSUE) if exp_stop low.
//  No-hit line: line_done 2 cycles after handshake; line_ready again the next cycle.
//  Ascending shift order guaranteed within a line.
//  rst mid-operation: abandon line, drop pending hits, clear seed_loaded; no line_done pulse.
//  cfg_valid outside IDLE ignored.
// STRUCTURE
//  blast_pkg: LINE_W, SEED_W, STEP, N_POS, state enum {IDLE,MATCH,SCAN,ISSUE,WAIT}.
//  Sub-module seed_prienc: combinational N_POS-bit lowest-set-bit encoder -> {found, idx[7:0]}.
//  Compare array, vector register, FSM and counters in the top.
// TESTING
//  1 Seed 22'h15A5A placed at bit 100 only, line_idx 7 -> one hit_start, shift=100, line=7,
//    qloc=cfg_loc; after exp_stop pulse, line_done within 2 cycles.
//  2 Matches at shifts 0, 2, 490 -> three pulses in ascending order; each only after prior stop rise.
//  3 Seed 0, all-zero line -> exactly 16 hits, hit_overflow=1, line_done; hit_total=16.
//  4 No match -> no hit_start; line_done 2 cycles after handshake; line_ready back high.
//  5 exp_stop held high at ISSUE -> no pulse until it drops; then exactly one hit_start.
//  6 rst asserted in WAIT -> all outputs 0, line_ready=0 until new cfg_valid; no line_done.

Source files
------------

// File: rtl/seed_hit_scanner_pkg.sv
// Shared geometry, state encoding and small helpers for the seed hit scanner.
package seed_hit_scanner_pkg;

  localparam int LINE_W   = 512;
  localparam int SEED_W   = 22;
  localparam int STEP     = 2;
  localparam int MAX_HITS = 16;
  localparam int N_POS    = (LINE_W - SEED_W) / STEP + 1;
  localparam int IDX_W    = 8;
  localparam int LOC_W    = 9;
  localparam int LIDX_W   = 17;
  localparam int CNT_W    = 5;
  localparam int TOT_W    = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MATCH = 3'd1,
    SCAN  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4
  } state_t;

  // Hit counter that sticks at all-ones instead of wrapping.
  function automatic logic [TOT_W-1:0] sat_inc(input logic [TOT_W-1:0] v);
    return (v == {TOT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

  // Window index to bit offset within the DB line.
  function automatic logic [LOC_W-1:0] idx_to_shift(input logic [IDX_W-1:0] idx);
    return {idx, 1'b0};
  endfunction

endpackage

// File: rtl/seed_hit_scanner_if.sv
// Config, DB line, hit and status signals between the scanner and its neighbours.
interface seed_hit_scanner_if;
  import seed_hit_scanner_pkg::*;

  logic              cfg_valid;
  logic [SEED_W-1:0] cfg_seed;
  logic [LOC_W-1:0]  cfg_loc;
  logic              line_valid;
  logic              line_ready;
  logic [LINE_W-1:0] line_data;
  logic [LIDX_W-1:0] line_idx;
  logic              hit_start;
  logic [LOC_W-1:0]  hit_shift;
  logic [LIDX_W-1:0] hit_line;
  logic [LOC_W-1:0]  hit_qloc;
  logic              exp_stop;
  logic              line_done;
  logic [TOT_W-1:0]  hit_total;
  logic              hit_overflow;

  modport master (
    output cfg_valid, cfg_seed, cfg_loc, line_valid, line_data, line_idx, exp_stop,
    input  line_ready, hit_start, hit_shift, hit_line, hit_qloc, line_done, hit_total, hit_overflow
  );

  modport slave (
    input  cfg_valid, cfg_seed, cfg_loc, line_valid, line_data, line_idx, exp_stop,
    output line_ready, hit_start, hit_shift, hit_line, hit_qloc, line_done, hit_total, hit_overflow
  );

endinterface

// File: rtl/seed_hit_scanner_prienc.sv
// Seed priority encoder: index of the lowest set bit of the window match vector.
module seed_hit_scanner_prienc
  import seed_hit_scanner_pkg::*;
(
  input  logic [N_POS-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk from the top down so the lowest set bit makes the final assignment.
  always_comb begin
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    for (int i = N_POS - 1; i >= 0; i--) begin
      found = found | vec[i];
      idx   = vec[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/seed_hit_scanner.sv
// Locates every base-aligned copy of the query seed in a DB line and hands the
// matches to the extender one at a time, lowest shift first.
module seed_hit_scanner
  import seed_hit_scanner_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  seed_hit_scanner_if.slave bus
);

  state_t            state_q, state_d;
  logic              seed_loaded_q, seed_loaded_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [LOC_W-1:0]  loc_q, loc_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic [LIDX_W-1:0] lidx_q, lidx_d;
  logic [N_POS-1:0]  vec_q, vec_d;
  logic [N_POS-1:0]  cmp_s;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LOC_W-1:0]  hit_shift_q, hit_shift_d;
  logic [LIDX_W-1:0] hit_line_q, hit_line_d;
  logic [LOC_W-1:0]  hit_qloc_q, hit_qloc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TOT_W-1:0]  total_q, total_d;
  logic              ovf_q, ovf_d;
  logic              stop_q;
  logic              pe_found_s;
  logic [IDX_W-1:0]  pe_idx_s;
  logic              line_ready_s, hit_start_s, line_done_s;

  seed_hit_scanner_prienc u_prienc (
    .vec   (vec_q),
    .found (pe_found_s),
    .idx   (pe_idx_s)
  );

  // One comparator per base-aligned window; windows never straddle two lines.
  always_comb begin
    cmp_s = {N_POS{1'b0}};
    for (int j = 0; j < N_POS; j++) begin
      cmp_s[j] = (data_q[STEP*j +: SEED_W] == seed_q);
    end
  end

  always_comb begin
    state_d       = state_q;
    seed_loaded_d = seed_loaded_q;
    seed_d        = seed_q;
    loc_d         = loc_q;
    data_d        = data_q;
    lidx_d        = lidx_q;
    vec_d         = vec_q;
    idx_d         = idx_q;
    hit_shift_d   = hit_shift_q;
    hit_line_d    = hit_line_q;
    hit_qloc_d    = hit_qloc_q;
    cnt_d         = cnt_q;
    total_d       = total_q;
    ovf_d         = ovf_q;
    line_ready_s  = 1'b0;
    hit_start_s   = 1'b0;
    line_done_s   = 1'b0;

    case (state_q)
      IDLE: begin
        // A config write takes the cycle, so the line is held off rather than accepted.
        line_ready_s = seed_loaded_q & ~bus.cfg_valid;
        if (bus.cfg_valid) begin
          seed_loaded_d = 1'b1;
          seed_d        = bus.cfg_seed;
          loc_d         = bus.cfg_loc;
        end else if (bus.line_valid && line_ready_s) begin
          data_d  = bus.line_data;
          lidx_d  = bus.line_idx;
          cnt_d   = {CNT_W{1'b0}};
          state_d = MATCH;
        end else begin
          state_d = IDLE;
        end
      end
      MATCH: begin
        vec_d   = cmp_s;
        state_d = SCAN;
      end
      SCAN: begin
        if (!pe_found_s || cnt_q == CNT_W'(MAX_HITS)) begin
          line_done_s = 1'b1;
          ovf_d       = ovf_q | pe_found_s;
          vec_d       = {N_POS{1'b0}};
          state_d     = IDLE;
        end else begin
          idx_d       = pe_idx_s;
          hit_shift_d = idx_to_shift(pe_idx_s);
          hit_line_d  = lidx_q;
          hit_qloc_d  = loc_q;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // A stop still high from the previous extension means the extender is not ready yet.
        if (!bus.exp_stop) begin
          hit_start_s  = 1'b1;
          vec_d[idx_q] = 1'b0;
          cnt_d        = cnt_q + 5'd1;
          total_d      = sat_inc(total_q);
          state_d      = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (bus.exp_stop && !stop_q) begin
          state_d = SCAN;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, configuration, line and hit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      seed_loaded_q <= 1'b0;
      seed_q        <= {SEED_W{1'b0}};
      loc_q         <= {LOC_W{1'b0}};
      data_q        <= {LINE_W{1'b0}};
      lidx_q        <= {LIDX_W{1'b0}};
      vec_q         <= {N_POS{1'b0}};
      idx_q         <= {IDX_W{1'b0}};
      hit_shift_q   <= {LOC_W{1'b0}};
      hit_line_q    <= {LIDX_W{1'b0}};
      hit_qloc_q    <= {LOC_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      total_q       <= {TOT_W{1'b0}};
      ovf_q         <= 1'b0;
      stop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      seed_loaded_q <= seed_loaded_d;
      seed_q        <= seed_d;
      loc_q         <= loc_d;
      data_q        <= data_d;
      lidx_q        <= lidx_d;
      vec_q         <= vec_d;
      idx_q         <= idx_d;
      hit_shift_q   <= hit_shift_d;
      hit_line_q    <= hit_line_d;
      hit_qloc_q    <= hit_qloc_d;
      cnt_q         <= cnt_d;
      total_q       <= total_d;
      ovf_q         <= ovf_d;
      stop_q        <= bus.exp_stop;
    end
  end

  assign bus.line_ready   = line_ready_s;
  assign bus.hit_start    = hit_start_s;
  assign bus.line_done    = line_done_s;
  assign bus.hit_shift    = hit_shift_q;
  assign bus.hit_line     = hit_line_q;
  assign bus.hit_qloc     = hit_qloc_q;
  assign bus.hit_total    = total_q;
  assign bus.hit_overflow = ovf_q;

endmodule

// File: tb/tb_seed_hit_scanner.sv
// Bench for seed_hit_scanner: acts as the extender and checks every hit against a
// reference list of matching shifts computed directly from the line contents.
module tb_seed_hit_scanner;
  import seed_hit_scanner_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seed_hit_scanner_if bus ();

  seed_hit_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                vectors     = 0;
  int                miscompares = 0;
  int                model_total = 0;
  logic              model_ovf   = 1'b0;
  logic [SEED_W-1:0] cur_seed    = '0;
  logic [LOC_W-1:0]  cur_loc     = '0;
  int                exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every bit offset (stride of one base) at which the seed appears in the line.
  task automatic build_model(input logic [LINE_W-1:0] d);
    exp_q.delete();
    for (int b = 0; b + SEED_W <= LINE_W; b += STEP) begin
      if (d[b +: SEED_W] == cur_seed) exp_q.push_back(b);
    end
  endtask

  task automatic do_cfg(input logic [SEED_W-1:0] s, input logic [LOC_W-1:0] l);
    bus.cfg_valid = 1'b1;
    bus.cfg_seed  = s;
    bus.cfg_loc   = l;
    step();
    bus.cfg_valid = 1'b0;
    cur_seed      = s;
    cur_loc       = l;
  endtask

  task automatic send_line(input logic [LINE_W-1:0] d, input logic [LIDX_W-1:0] li, output bit ok);
    int waited;
    bus.line_data  = d;
    bus.line_idx   = li;
    bus.line_valid = 1'b1;
    ok     = 1'b0;
    waited = 0;
    while (!ok && waited < 50) begin
      #1;
      ok = bus.line_ready;
      step();
      waited++;
    end
    bus.line_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL line_accept: line_ready stayed %0b, required 1 within 50 cycles", bus.line_ready);
    end
  endtask

  // Feeds one line and plays extender: stop is raised a random delay after each hit.
  // hold > 0 keeps exp_stop high for the first hold cycles after the handshake.
  task automatic run_line(input logic [LINE_W-1:0] d, input logic [LIDX_W-1:0] li, input int hold);
    int n_exp, got, cyc, stop_at, wake_hit, wake_done, exp_sh;
    bit ok, done;
    logic [LOC_W-1:0] last_shift;
    build_model(d);
    n_exp      = (exp_q.size() > MAX_HITS) ? MAX_HITS : exp_q.size();
    last_shift = bus.hit_shift;
    send_line(d, li, ok);
    if (!ok) return;
    got = 0; cyc = 0; done = 1'b0; stop_at = -1;
    wake_hit  = (hold > 2) ? hold : 2;
    wake_done = 1;
    while (!done && cyc < 400) begin
      bus.exp_stop = (cyc < hold) || (cyc == stop_at);
      #1;
      if (bus.hit_start) begin
        vectors++;
        exp_sh = (got < n_exp) ? exp_q[got] : -1;
        if (got >= n_exp || cyc != wake_hit || bus.hit_shift !== LOC_W'(exp_sh) ||
            bus.hit_line !== li || bus.hit_qloc !== cur_loc) begin
          miscompares++;
          $display("FAIL hit_%0d: cyc=%0d shift=%0d line=%0d qloc=%0d, required cyc=%0d shift=%0d line=%0d qloc=%0d",
                   got, cyc, bus.hit_shift, bus.hit_line, bus.hit_qloc, wake_hit, exp_sh, li, cur_loc);
        end
        if (got < n_exp) last_shift = LOC_W'(exp_sh);
        got++;
        model_total++;
        stop_at   = cyc + int'($urandom_range(1, 4));
        wake_hit  = stop_at + 2;
        wake_done = stop_at + 1;
      end
      if (bus.line_done) begin
        done = 1'b1;
        vectors++;
        if (got != n_exp || cyc != wake_done) begin
          miscompares++;
          $display("FAIL line_done: hits=%0d cyc=%0d, required hits=%0d cyc=%0d", got, cyc, n_exp, wake_done);
        end
      end
      step();
      cyc++;
    end
    bus.exp_stop = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL line_done_timeout: no line_done after %0d cycles, required one", cyc);
    end
    if (exp_q.size() > MAX_HITS) model_ovf = 1'b1;
    #1;
    vectors++;
    if (bus.line_ready !== 1'b1 || bus.hit_total !== TOT_W'(model_total) ||
        bus.hit_overflow !== model_ovf || bus.hit_shift !== last_shift) begin
      miscompares++;
      $display("FAIL line_end: ready=%0b total=%0d ovf=%0b shift=%0d, required ready=1 total=%0d ovf=%0b shift=%0d",
               bus.line_ready, bus.hit_total, bus.hit_overflow, bus.hit_shift, model_total, model_ovf, last_shift);
    end
  endtask

  task automatic check_quiet(input string name);
    vectors++;
    if (bus.hit_start !== 1'b0 || bus.line_done !== 1'b0 || bus.line_ready !== 1'b0 ||
        bus.hit_overflow !== 1'b0 || bus.hit_total !== 16'd0 || bus.hit_shift !== 9'd0 ||
        bus.hit_line !== 17'd0 || bus.hit_qloc !== 9'd0) begin
      miscompares++;
      $display("FAIL %s: start=%0b done=%0b ready=%0b ovf=%0b total=%0d shift=%0d line=%0d qloc=%0d, required all 0",
               name, bus.hit_start, bus.line_done, bus.line_ready, bus.hit_overflow, bus.hit_total,
               bus.hit_shift, bus.hit_line, bus.hit_qloc);
    end
  endtask

  task automatic test_reset();
    bus.cfg_valid = 1'b0; bus.cfg_seed = '0; bus.cfg_loc = '0;
    bus.line_valid = 1'b0; bus.line_data = '0; bus.line_idx = '0; bus.exp_stop = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check_quiet("reset_state");
    // Without a seed, an offered line must not be taken.
    bus.line_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("no_seed_no_accept");
    end
    bus.line_valid = 1'b0;
  endtask

  task automatic test_single_hit();
    logic [LINE_W-1:0] d;
    do_cfg(22'h15A5A, 9'd37);
    d = '0;
    d[100 +: SEED_W] = 22'h15A5A;
    run_line(d, 17'd7, 0);
  endtask

  task automatic test_edge_shifts();
    logic [LINE_W-1:0] d;
    do_cfg(22'h3FFFFF, 9'd300);
    d = '0;
    d[23:0]    = 24'hFFFFFF;
    d[511:490] = 22'h3FFFFF;
    run_line(d, 17'h1ABCD, 0);
  endtask

  task automatic test_overflow();
    do_cfg(22'h0, 9'd5);
    run_line({LINE_W{1'b0}}, 17'd99, 0);
  endtask

  task automatic test_no_match();
    do_cfg(22'h2C3D1, 9'd12);
    run_line({LINE_W{1'b0}}, 17'd3, 0);
  endtask

  task automatic test_stop_hold();
    logic [LINE_W-1:0] d;
    do_cfg(22'h0F0F1, 9'd400);
    d = '0;
    d[250 +: SEED_W] = 22'h0F0F1;
    run_line(d, 17'd42, 6);
  endtask

  task automatic test_cfg_priority();
    bus.cfg_valid  = 1'b1;
    bus.cfg_seed   = 22'h12345;
    bus.cfg_loc    = 9'd77;
    bus.line_valid = 1'b1;
    bus.line_data  = '0;
    #1;
    vectors++;
    if (bus.line_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_priority_ready: line_ready=%0b, required 0", bus.line_ready);
    end
    step();
    bus.cfg_valid  = 1'b0;
    bus.line_valid = 1'b0;
    cur_seed = 22'h12345;
    cur_loc  = 9'd77;
    #1;
    vectors++;
    if (bus.line_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_priority_idle: line_ready=%0b, required 1", bus.line_ready);
    end
  endtask

  task automatic test_random_lines();
    logic [LINE_W-1:0] d;
    int pos;
    for (int n = 0; n < 12; n++) begin
      if (n == 0 || $urandom_range(0, 1) == 1) do_cfg(SEED_W'($urandom()), LOC_W'($urandom()));
      for (int w = 0; w < LINE_W / 32; w++) d[w*32 +: 32] = $urandom();
      for (int k = int'($urandom_range(0, 5)); k > 0; k--) begin
        pos = 2 * int'($urandom_range(0, N_POS - 1));
        d[pos +: SEED_W] = cur_seed;
      end
      run_line(d, LIDX_W'($urandom()), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
    end
  endtask

  task automatic test_reset_mid();
    logic [LINE_W-1:0] d;
    bit ok;
    do_cfg(22'h1E2D3, 9'd9);
    d = '0;
    d[40 +: SEED_W]  = 22'h1E2D3;
    d[200 +: SEED_W] = 22'h1E2D3;
    send_line(d, 17'd11, ok);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_total = 0;
    model_ovf   = 1'b0;
    #1;
    check_quiet("reset_mid_state");
    bus.line_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.exp_stop = i[0];
      step();
      check_quiet("reset_mid_quiet");
    end
    bus.line_valid = 1'b0;
    bus.exp_stop   = 1'b0;
    do_cfg(22'h1E2D3, 9'd9);
    run_line(d, 17'd12, 0);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_edge_shifts();
    test_overflow();
    test_no_match();
    test_stop_hold();
    test_cfg_priority();
    test_random_lines();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
